// File: rtl/alu_sequencer.sv
// alu_sequencer: Wishbone pipelined bus master that shares an 8-bit ALU slave between
// two command requesters. Each command is (a, b, op). The command sequence is:
//   1. write a to address 0x00,
//   2. write b to address 0x01,
//   3. read address op,
//   4. return the result tagged with the requester id.
// Arbitration is round-robin, and only one command is in flight at a time.
//
// Parameters:
//   TIMEOUT_CYCLES  ack-less cycles before a command is aborted (watchdog builds only)
//   OUTST_W         width of the outstanding-transfer counter
//
// Ports:
//   i_clk, reset                   clock (rising edge), async active-low reset
//   i_reqN_valid / o_reqN_ready    command handshake for requester N (N = 0, 1)
//   i_reqN_a, i_reqN_b, i_reqN_op  operands and ALU read address
//   o_rsp_valid / i_rsp_ready      result handshake
//   o_rsp_data, o_rsp_id           result and the id of the requester that issued it
//   o_rsp_err                      command aborted
//   o_wb_stb, o_wb_we              bus strobe and write enable
//   o_wb_addr, o_wb_data           bus address and write data
//   i_wb_ack, i_wb_stall           slave acknowledge and stall
//   i_wb_data                      slave read data
//
// Optional feature: define ALU_SEQ_TIMEOUT_EN to enable the ack watchdog. A command whose
// watchdog expires completes with o_rsp_err=1 and o_rsp_data=0x00. Without the macro,
// o_rsp_err is tied to 0 and the sequencer waits for acks indefinitely.

module alu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned OUTST_W        = 4
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    input  logic [7:0] i_req0_a,
    input  logic [7:0] i_req0_b,
    input  logic [7:0] i_req0_op,
    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    input  logic [7:0] i_req1_a,
    input  logic [7:0] i_req1_b,
    input  logic [7:0] i_req1_op,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_id,
    output logic       o_rsp_err,
    output logic       o_wb_stb,
    output logic       o_wb_we,
    output logic [7:0] o_wb_addr,
    output logic [7:0] o_wb_data,
    input  logic       i_wb_ack,
    input  logic       i_wb_stall,
    input  logic [7:0] i_wb_data
);

    typedef enum logic [2:0] {
        StIdle,
        StWrA,
        StWrB,
        StRd,
        StDrain,
        StResp
    } state_e;

    localparam logic [OUTST_W-1:0] OutstMax = {OUTST_W{1'b1}};
    localparam logic [OUTST_W-1:0] OutstOne = OUTST_W'(1);

    state_e             state_q;
    logic               last_grant_q;
    logic [7:0]         b_q;
    logic [7:0]         op_q;
    logic [OUTST_W-1:0] outst_q;
    logic [1:0]         ack_cnt_q;

    logic               grant_any;
    logic               grant_id;
    logic               busy;
    logic               issue;
    logic               ack_take;
    logic [OUTST_W-1:0] outst_d;
    logic               read_ack;
    logic               timeout;

    always_comb begin
        grant_any = i_req0_valid | i_req1_valid;
        // On contention the requester that did not win last time gets the grant.
        if (i_req0_valid && i_req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = i_req1_valid;
        end
        o_req0_ready = reset && (state_q == StIdle) && grant_any && !grant_id;
        o_req1_ready = reset && (state_q == StIdle) && grant_any && grant_id;

        busy  = state_q inside {StWrA, StWrB, StRd, StDrain};
        issue = o_wb_stb && !i_wb_stall;
        // Surplus acks (counter already empty) are discarded rather than wrapping the count.
        ack_take = i_wb_ack && ((outst_q != '0) || issue);
        outst_d  = outst_q;
        if (issue && !ack_take) begin
            outst_d = outst_q + OutstOne;
        end else if (!issue && ack_take) begin
            outst_d = outst_q - OutstOne;
        end

        // The two write acks come first, so the third ack of the command answers the read.
        read_ack = (state_q == StRd) && i_wb_ack && (ack_cnt_q == 2'd2);
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned WdW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_q;
    logic           err_q;

    assign timeout   = busy && !i_wb_ack && (wd_q == WdLast);
    assign o_rsp_err = err_q;

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (!busy || i_wb_ack || timeout) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + WdW'(1);
            end
            if (timeout) begin
                err_q <= 1'b1;
            end else if (state_q == StResp && i_rsp_ready) begin
                err_q <= 1'b0;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            b_q          <= '0;
            op_q         <= '0;
            outst_q      <= '0;
            ack_cnt_q    <= '0;
            o_wb_stb     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_addr    <= '0;
            o_wb_data    <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_id     <= 1'b0;
        end else begin
            if (busy) begin
                outst_q <= outst_d;
                if (i_wb_ack && ack_cnt_q != 2'd3) begin
                    ack_cnt_q <= ack_cnt_q + 2'd1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        last_grant_q <= grant_id;
                        o_rsp_id     <= grant_id;
                        b_q          <= grant_id ? i_req1_b : i_req0_b;
                        op_q         <= grant_id ? i_req1_op : i_req0_op;
                        outst_q      <= '0;
                        ack_cnt_q    <= '0;
                        o_wb_stb     <= 1'b1;
                        o_wb_we      <= 1'b1;
                        o_wb_addr    <= 8'h00;
                        o_wb_data    <= grant_id ? i_req1_a : i_req0_a;
                        state_q      <= StWrA;
                    end
                end
                StWrA: begin
                    if (!i_wb_stall) begin
                        o_wb_addr <= 8'h01;
                        o_wb_data <= b_q;
                        state_q   <= StWrB;
                    end
                end
                StWrB: begin
                    if (!i_wb_stall) begin
                        o_wb_we   <= 1'b0;
                        o_wb_addr <= op_q;
                        o_wb_data <= 8'h00;
                        state_q   <= StRd;
                    end
                end
                StRd: begin
                    if (read_ack) begin
                        o_rsp_data <= i_wb_data;
                        o_wb_stb   <= 1'b0;
                        state_q    <= StDrain;
                    end else begin
                        // Keep re-issuing the read so slave data stays valid on the ack
                        // cycle, but back off while the outstanding counter is full.
                        o_wb_stb <= (outst_d != OutstMax);
                    end
                end
                StDrain: begin
                    if (outst_q == '0 || (outst_q == OutstOne && i_wb_ack)) begin
                        o_rsp_valid <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (timeout) begin
                o_wb_stb    <= 1'b0;
                o_wb_we     <= 1'b0;
                outst_q     <= '0;
                o_rsp_data  <= 8'h00;
                o_rsp_valid <= 1'b1;
                state_q     <= StResp;
            end
        end
    end

endmodule
